// File: rtl/dac_sample_sched.sv
// dac_sample_sched
//
// Schedules DAC updates at a fixed sample period. It buffers words from the
// serial-to-parallel front end in a small FIFO and releases one word to the
// R2R output register every div+1 clock cycles. Because of the buffer, the
// DAC update timing does not depend on when the words arrive over SPI.
//
// Handshake: in_valid qualifies in_data for exactly one cycle, and there is
// no ready. A word that arrives while the FIFO is full and nothing is popped
// in that cycle is dropped, and overflow pulses on the following cycle.
// In IDLE, and in any cycle with en low, the FIFO is flushed and incoming
// words are discarded silently.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           scheduler enable (level)
//   div          sample period minus 1, in clk cycles; sampled at reload only
//   in_data      word from the front end, qualified by in_valid
//   in_valid     one-cycle pulse qualifying in_data
//   dac_out      registered DAC code (midscale after reset)
//   dac_strobe   one-cycle pulse in the cycle dac_out shows a new word
//   fifo_level   words currently buffered (post-update)
//   overflow     one-cycle pulse: an incoming word was dropped
//   underrun     one-cycle pulse: a sample tick found the FIFO empty
//   busy         high while in PRIME or RUN
//   underrun_cnt saturating underrun count; present only when the macro
//                DAC_UNDERRUN_CNT_EN is defined, and cleared in IDLE
module dac_sample_sched #(
  parameter int D_W   = 8,
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [DIV_W-1:0]         div,
  input  logic [D_W-1:0]           in_data,
  input  logic                     in_valid,
  output logic [D_W-1:0]           dac_out,
  output logic                     dac_strobe,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     underrun,
  output logic                     busy
`ifdef DAC_UNDERRUN_CNT_EN
  ,
  output logic [7:0]               underrun_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] LVL_HALF = (PW+1)'(DEPTH/2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [DIV_W-1:0] cnt;
  logic [D_W-1:0]   mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic flush;
  logic tick;
  logic pop;
  logic push;
  logic drop;

  // A tick that coincides with en falling is still serviced. Only the FIFO
  // contents are flushed in that same cycle.
  always_comb begin
    flush = (state == S_IDLE) || !en;
    tick  = (state == S_RUN) && (cnt == '0);
    pop   = tick && (fifo_level != '0);
    // At full, a simultaneous pop frees the slot that this write takes.
    push  = in_valid && !flush && ((fifo_level < LVL_FULL) || pop);
    drop  = in_valid && !flush && (fifo_level == LVL_FULL) && !pop;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_PRIME;
        S_PRIME: if (fifo_level >= LVL_HALF) state_nxt = S_RUN;
        S_RUN:   if (tick && !pop) state_nxt = S_PRIME;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      dac_out    <= {1'b1, {(D_W-1){1'b0}}};
      dac_strobe <= 1'b0;
      underrun   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != S_IDLE);
      dac_strobe <= pop;
      underrun   <= tick && !pop;
      overflow   <= drop;
      if (pop) dac_out <= mem[rd_ptr];
    end
  end

  // The period counter loads div when RUN is entered and at every tick.
  // A change to div in the middle of a period therefore applies only from
  // the next period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || state == S_IDLE) begin
      cnt <= '0;
    end else if (state == S_PRIME) begin
      if (fifo_level >= LVL_HALF) cnt <= div;
    end else if (state == S_RUN) begin
      if (tick) cnt <= div;
      else      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
    end
  end

  // The storage array has no reset. Reads are gated by fifo_level, so a
  // location is never read before it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifdef DAC_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (state == S_IDLE) begin
      underrun_cnt <= '0;
    end else if (tick && !pop && underrun_cnt != 8'hFF) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_sample_sched.sv
module tb_dac_sample_sched;

  localparam int D_W   = 8;
  localparam int DEPTH = 4;
  localparam int DIV_W = 16;

  localparam int PH_IDLE  = 0;
  localparam int PH_PRIME = 1;
  localparam int PH_RUN   = 2;

  // ---------------- clock / reset / DUT ----------------
  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   en = 1'b0;
  logic [DIV_W-1:0]       div = '0;
  logic [D_W-1:0]         in_data = '0;
  logic                   in_valid = 1'b0;
  logic [D_W-1:0]         dac_out;
  logic                   dac_strobe;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   overflow;
  logic                   underrun;
  logic                   busy;
`ifdef DAC_UNDERRUN_CNT_EN
  logic [7:0]             underrun_cnt;
`endif

  always #5 clk = ~clk;

  dac_sample_sched #(.D_W(D_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .div        (div),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .dac_out    (dac_out),
    .dac_strobe (dac_strobe),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .underrun   (underrun),
    .busy       (busy)
`ifdef DAC_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (scoreboard) ----------------
  logic [D_W-1:0] exp_q[$];
  int             m_phase;
  int             m_cnt;
  logic [D_W-1:0] m_dac;
  bit             e_strobe, e_ovf, e_udr;
  int             m_ucnt;

  task automatic model_reset();
    exp_q.delete();
    m_phase  = PH_IDLE;
    m_cnt    = 0;
    m_dac    = 8'h80;
    e_strobe = 0;
    e_ovf    = 0;
    e_udr    = 0;
    m_ucnt   = 0;
  endtask

  // One clock edge of the scheduler, described in terms of words, periods and phases.
  task automatic model_step();
    int  lvl0;
    bit  tick;
    bit  was_idle;
    lvl0     = exp_q.size();
    was_idle = (m_phase == PH_IDLE);
    tick     = (m_phase == PH_RUN) && (m_cnt == 0);
    e_strobe = 0;
    e_ovf    = 0;
    e_udr    = 0;
    if (tick) begin
      if (exp_q.size() > 0) begin
        m_dac    = exp_q.pop_front();
        e_strobe = 1;
      end else begin
        e_udr = 1;
      end
    end
    if (was_idle || !en) begin
      exp_q.delete();
    end else if (in_valid) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(in_data);
      else                      e_ovf = 1;
    end
    if (was_idle)                 m_ucnt = 0;
    else if (e_udr && m_ucnt < 255) m_ucnt++;
    if (!en) begin
      m_phase = PH_IDLE;
      m_cnt   = 0;
    end else if (m_phase == PH_IDLE) begin
      m_phase = PH_PRIME;
    end else if (m_phase == PH_PRIME) begin
      if (lvl0 >= DEPTH/2) begin
        m_phase = PH_RUN;
        m_cnt   = int'(div);
      end
    end else begin
      if (tick) begin
        m_cnt = int'(div);
        if (e_udr) m_phase = PH_PRIME;
      end else begin
        m_cnt--;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("dac_out",    dac_out,    m_dac);
    check_eq("dac_strobe", dac_strobe, e_strobe);
    check_eq("fifo_level", fifo_level, exp_q.size());
    check_eq("overflow",   overflow,   e_ovf);
    check_eq("underrun",   underrun,   e_udr);
    check_eq("busy",       busy,       (m_phase != PH_IDLE));
`ifdef DAC_UNDERRUN_CNT_EN
    check_eq("underrun_cnt", underrun_cnt, m_ucnt);
`endif
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit e, input int d, input bit v, input logic [D_W-1:0] data);
    en       = e;
    div      = DIV_W'(d);
    in_valid = v;
    in_data  = data;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int ovf_seen;
    int strobes;
    logic [D_W-1:0] held;

    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    check_eq("reset_dac_midscale", dac_out, 8'h80);
    rst_n = 1'b1;
    repeat (4) step();

    // Priming with two words, then two strobes 4 cycles apart, then underrun.
    drive(1, 3, 0, 8'h00);
    step();
    drive(1, 3, 1, 8'h11);
    step();
    drive(1, 3, 1, 8'h22);
    step();
    drive(1, 3, 0, 8'h00);
    n = 0;
    do begin step(); n++; end while (dac_strobe !== 1'b1 && n < 20);
    check_eq("first_strobe_latency", n, 5);
    check_eq("first_word", dac_out, 8'h11);
    n = 0;
    do begin step(); n++; end while (dac_strobe !== 1'b1 && n < 20);
    check_eq("strobe_period", n, 4);
    check_eq("second_word", dac_out, 8'h22);
    n = 0;
    do begin step(); n++; end while (underrun !== 1'b1 && n < 20);
    check_eq("underrun_latency", n, 4);
    check_eq("underrun_dac_hold", dac_out, 8'h22);
    check_eq("underrun_busy", busy, 1);
`ifdef DAC_UNDERRUN_CNT_EN
    check_eq("underrun_cnt_one", underrun_cnt, 1);
`endif

    // Six back-to-back words with a long period: four kept, two dropped.
    ovf_seen = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 100, 1, D_W'($urandom));
      step();
      if (overflow === 1'b1) ovf_seen++;
    end
    check_eq("overflow_count", ovf_seen, 2);
    check_eq("full_level", fifo_level, 4);

    // div=0 from the next reload: full FIFO, write on every tick.
    for (int i = 0; i < 120; i++) begin
      drive(1, 0, 1, D_W'($urandom));
      step();
    end
    check_eq("full_pop_push_level", fifo_level, 4);
    check_eq("full_pop_push_no_ovf", overflow, 0);

    // Level 3, then drop en: flush, hold dac_out, then re-prime.
    drive(1, 0, 0, 8'h00);
    step();
    check_eq("level_before_disable", fifo_level, 3);
    drive(0, 0, 0, 8'h00);
    step();
    check_eq("disable_level", fifo_level, 0);
    check_eq("disable_busy", busy, 0);
    held = dac_out;
    repeat (3) step();
    check_eq("idle_dac_hold", dac_out, held);
    drive(1, 0, 0, 8'h00);
    step();
    drive(1, 0, 1, D_W'($urandom));
    step();
    drive(1, 0, 0, 8'h00);
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dac_strobe === 1'b1) strobes++;
    end
    check_eq("reprime_no_strobe", strobes, 0);
    drive(1, 0, 1, D_W'($urandom));
    step();
    drive(1, 0, 0, 8'h00);
    repeat (6) step();

    // Reset in the middle of operation.
    drive(1, 2, 1, 8'h5A);
    repeat (8) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Randomized segments.
    for (int s = 0; s < 60; s++) begin
      int  len;
      int  vprob;
      int  dv;
      bit  e;
      len   = $urandom_range(5, 40);
      vprob = $urandom_range(0, 100);
      dv    = $urandom_range(0, 6);
      e     = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < len; c++) begin
        drive(e, dv, ($urandom_range(0, 99) < vprob), D_W'($urandom));
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
